// File: rtl/spi_slave_core_pkg.sv
// Shared SPI constants and helpers, common to the slave and master cores.
package spi_slave_core_pkg;

  localparam int unsigned SPI_WORD_W         = 32;
  localparam int unsigned SPI_BYTE_W         = 8;
  localparam int unsigned SPI_BYTES_PER_WORD = 4;
  localparam int unsigned BIT_CNT_W          = $clog2(SPI_BYTE_W);
  localparam int unsigned BYTE_CNT_W         = $clog2(SPI_BYTES_PER_WORD);
  localparam int unsigned WORD_IDX_W         = $clog2(SPI_WORD_W);

  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

  // Bit position inside the word: byte-major, LSB-first within each byte.
  function automatic logic [WORD_IDX_W-1:0] bit_index(input logic [BYTE_CNT_W-1:0] byte_idx,
                                                      input logic [BIT_CNT_W-1:0]  bit_idx);
    return {byte_idx, bit_idx};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous input with rise/fall pulses on the synced level.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
      prev_q <= ResetVal;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: one 32-bit word spread across four ss_n byte frames, LSB-first per byte.
module spi_slave_core
  import spi_slave_core_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sclk_i,
  input  logic                  ss_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  output logic [SPI_WORD_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [SPI_WORD_W-1:0] tx_data_i,
  input  logic                  tx_wr_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  output logic                  byte_err_o,
  output logic                  frame_err_o
);

  localparam int unsigned IdleCntW = $clog2(IDLE_TIMEOUT + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (sclk_i),
    .q_o    (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (ss_n_i),
    .q_o    (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (mosi_i),
    .q_o    (mosi_lvl),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [SPI_WORD_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [SPI_WORD_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
  logic [IdleCntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic tx_ready_q, tx_ready_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic word_done_q, word_done_d, rx_valid_q, rx_valid_d;
  logic underrun_q, underrun_d, byte_err_q, byte_err_d, frame_err_q, frame_err_d;
  logic [SPI_WORD_W-1:0] rx_next;
  logic [WORD_IDX_W-1:0] idx;

  assign idx = bit_index(byte_cnt_q, bit_cnt_q);

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    idle_cnt_d  = idle_cnt_q;
    tx_ready_d  = tx_ready_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    word_done_d = 1'b0;
    rx_valid_d  = word_done_q;
    underrun_d  = 1'b0;
    byte_err_d  = 1'b0;
    frame_err_d = 1'b0;
    rx_next     = rx_shift_q;

    if (tx_wr_i && tx_ready_q) begin
      hold_d     = tx_data_i;
      tx_ready_d = 1'b0;
    end

    // ss_n edges take priority; any sclk edge in the same cycle is dropped.
    if (ss_rise) begin
      miso_oe_d = 1'b0;
      if (bit_cnt_q != '0) begin
        byte_err_d = 1'b1;
        bit_cnt_d  = '0;
      end
    end else if (ss_fall) begin
      miso_oe_d = 1'b1;
      if (byte_cnt_q == '0) begin
        if (!tx_ready_q) begin
          tx_shift_d = hold_q;
          tx_ready_d = 1'b1;
        end else if (tx_wr_i) begin
          // Bypass: the write goes straight to the shifter, holding stays empty.
          tx_shift_d = tx_data_i;
          hold_d     = hold_q;
          tx_ready_d = 1'b1;
        end else begin
          tx_shift_d = '0;
          underrun_d = 1'b1;
        end
      end
      miso_d = tx_shift_d[idx];
    end else if (!ss_lvl) begin
      if (sclk_rise) begin
        rx_next[idx] = mosi_lvl;
        rx_shift_d   = rx_next;
        bit_cnt_d    = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_CNT_W'(SPI_BYTE_W - 1)) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == BYTE_CNT_W'(SPI_BYTES_PER_WORD - 1)) begin
            rx_data_d   = rx_next;
            word_done_d = 1'b1;
          end
        end
      end else if (sclk_fall) begin
        miso_d = tx_shift_q[idx];
      end
    end

    if (ss_lvl && byte_cnt_q != '0) begin
      if (idle_cnt_q == IdleCntW'(IDLE_TIMEOUT - 1)) begin
        idle_cnt_d  = '0;
        byte_cnt_d  = '0;
        rx_shift_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      idle_cnt_q  <= '0;
      tx_ready_q  <= 1'b1;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      byte_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      idle_cnt_q  <= idle_cnt_d;
      tx_ready_q  <= tx_ready_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      byte_err_q  <= byte_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign miso_o        = miso_q;
  assign miso_oe_o     = miso_oe_q;
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = tx_ready_q;
  assign tx_underrun_o = underrun_q;
  assign byte_err_o    = byte_err_q;
  assign frame_err_o   = frame_err_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: bit-banged mode-0 master at clk/8 with an rx word scoreboard.
module tb_spi_slave_core;

  logic        clk, rst_n;
  logic        sclk, ss_n, mosi;
  logic        miso, miso_oe;
  logic [31:0] rx_data, tx_data;
  logic        rx_valid, tx_wr, tx_ready, tx_underrun, byte_err, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int n_underrun = 0, n_byte_err = 0, n_frame_err = 0;
  logic [31:0] rx_q[$];

  spi_slave_core #(.IDLE_TIMEOUT(64), .SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .sclk_i        (sclk),
    .ss_n_i        (ss_n),
    .mosi_i        (mosi),
    .miso_o        (miso),
    .miso_oe_o     (miso_oe),
    .rx_data_o     (rx_data),
    .rx_valid_o    (rx_valid),
    .tx_data_i     (tx_data),
    .tx_wr_i       (tx_wr),
    .tx_ready_o    (tx_ready),
    .tx_underrun_o (tx_underrun),
    .byte_err_o    (byte_err),
    .frame_err_o   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer and pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) check_eq("rx_spurious", 32'd1, 32'd0);
        else check_eq("rx_data", rx_data, rx_q.pop_front());
      end
      if (tx_underrun) n_underrun++;
      if (byte_err) n_byte_err++;
      if (frame_err) n_frame_err++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [31:0] d);
    @(negedge clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] mb);
    mb   = '0;
    ss_n = 1'b0;
    mosi = b[0];
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      sclk  = 1'b1;
      mb[i] = miso;
      wait_clk(4);
      sclk = 1'b0;
      if (i < 7) mosi = b[i+1];
      wait_clk(4);
    end
    ss_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic drain_rx();
    for (int i = 0; i < 20; i++) begin
      if (rx_q.size() == 0) break;
      wait_clk(1);
    end
    check_eq("rx_drain", rx_q.size(), 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] exp_miso);
    logic [7:0] mb;
    rx_q.push_back(w);
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k+:8], 8, mb);
      check_eq($sformatf("miso_byte%0d", k), {24'd0, mb}, {24'd0, exp_miso[8*k+:8]});
    end
    drain_rx();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_miso"}, {31'd0, miso}, 32'd0);
    check_eq({pfx, "_miso_oe"}, {31'd0, miso_oe}, 32'd0);
    check_eq({pfx, "_rx_data"}, rx_data, 32'd0);
    check_eq({pfx, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
    check_eq({pfx, "_tx_ready"}, {31'd0, tx_ready}, 32'd1);
    check_eq({pfx, "_pulses"}, {29'd0, tx_underrun, byte_err, frame_err}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] mb;
    int u0, b0, f0;
    rst_n = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_data = '0; tx_wr = 1'b0;
    wait_clk(3);
    check_reset_outputs("init");
    rst_n = 1'b1;
    wait_clk(4);

    // Loaded word; a second write while full must be ignored.
    u0 = n_underrun; b0 = n_byte_err; f0 = n_frame_err;
    write_tx(32'hA5C3_0FF0);
    check_eq("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    write_tx(32'hFFFF_FFFF);
    send_word(32'h1234_5678, 32'hA5C3_0FF0);
    check_eq("tx_ready_after", {31'd0, tx_ready}, 32'd1);
    check_eq("w1_errs", n_underrun - u0 + n_byte_err - b0 + n_frame_err - f0, 0);

    // Underrun: nothing written, miso all zero.
    u0 = n_underrun;
    send_word(32'hDEAD_BEEF, 32'h0000_0000);
    check_eq("underrun_cnt", n_underrun - u0, 1);

    // Aborted byte 2, then resent.
    b0 = n_byte_err; u0 = n_underrun;
    write_tx(32'h1122_3344);
    rx_q.push_back(32'hCAFE_BABE);
    send_byte(8'hBE, 8, mb); check_eq("be_miso0", {24'd0, mb}, 32'h44);
    send_byte(8'hBA, 8, mb); check_eq("be_miso1", {24'd0, mb}, 32'h33);
    send_byte(8'hFE, 5, mb);
    check_eq("byte_err_cnt", n_byte_err - b0, 1);
    send_byte(8'hFE, 8, mb); check_eq("be_miso2", {24'd0, mb}, 32'h22);
    send_byte(8'hCA, 8, mb); check_eq("be_miso3", {24'd0, mb}, 32'h11);
    drain_rx();
    check_eq("be_underrun", n_underrun - u0, 0);

    // Idle timeout after two bytes, then a fresh word that underruns.
    f0 = n_frame_err; u0 = n_underrun;
    write_tx(32'hCAFE_F00D);
    send_byte(8'hAA, 8, mb);
    send_byte(8'h55, 8, mb);
    wait_clk(80);
    check_eq("frame_err_cnt", n_frame_err - f0, 1);
    send_word(32'h0403_0201, 32'h0000_0000);
    check_eq("fe_underrun", n_underrun - u0, 1);

    // Reset mid-word.
    b0 = n_byte_err; f0 = n_frame_err; u0 = n_underrun;
    write_tx(32'h0BAD_0BAD);
    send_byte(8'hEE, 8, mb);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(4);
    write_tx(32'h55AA_33CC);
    send_word(32'h8765_4321, 32'h55AA_33CC);
    check_eq("rst_errs", n_underrun - u0 + n_byte_err - b0 + n_frame_err - f0, 0);

    wait_clk(10);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
